// File: rtl/la_scan_pkg.sv
// Shared definitions for the scan controller: FSM state encoding and the
// response-compaction MISR polynomial and its update step.
package la_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // x^16 + x^12 + x^3 + x + 1 (the x^16 term is implied by the shift-out)
  localparam logic [15:0] MISR_POLY = 16'h100B;

  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic din);
    misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {15'h0000, din};
  endfunction

endpackage

// File: rtl/la_scanmisr.sv
// 16-bit multiple-input signature register compacting the unloaded scan
// response one bit per enabled cycle.
module la_scanmisr
  import la_scan_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_din,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sig <= 16'h0000;
    end else if (i_clear) begin
      r_sig <= 16'h0000;
    end else if (i_en) begin
      r_sig <= misr_next(r_sig, i_din);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/la_scanctrl.sv
// Scan-chain controller: load (SHIFT), capture, unload with optional
// load/unload overlap. Define LA_SCANCTRL_MISR_EN to add the signature output.
module la_scanctrl
  import la_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int NCAPTURE  = 1,
  parameter     PROP      = "DEFAULT"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        next,
  input  logic        sin,
  output logic        sin_ready,
  input  logic        so,
  output logic        se,
  output logic        si,
  output logic        sout,
  output logic        sout_valid,
  output logic        busy,
  output logic        done
`ifdef LA_SCANCTRL_MISR_EN
  ,
  output logic [15:0] signature
`endif
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [3:0]    CAP_LAST = 4'(NCAPTURE - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cap_cnt;
  logic          r_se;
  logic          r_sin_ready;
  logic          r_sout_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_unused_prop;

  // PROP is a pass-through technology tag with no effect on the logic.
  assign w_unused_prop = ^PROP;

  // Output flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_cap_cnt    <= 4'd0;
      r_se         <= 1'b0;
      r_sin_ready  <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SHIFT;
            r_cnt        <= CNT_ZERO;
            r_se         <= 1'b1;
            r_sin_ready  <= 1'b1;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_state      <= ST_CAPTURE;
            r_cnt        <= CNT_ZERO;
            r_cap_cnt    <= 4'd0;
            r_se         <= 1'b0;
            r_sin_ready  <= 1'b0;
            r_sout_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          if (r_cap_cnt == CAP_LAST) begin
            r_cnt        <= CNT_ZERO;
            r_cap_cnt    <= 4'd0;
            r_se         <= 1'b1;
            r_sout_valid <= 1'b1;
            // A chained pattern reloads while the previous response unloads
            if (next) begin
              r_state     <= ST_SHIFT;
              r_sin_ready <= 1'b1;
            end else begin
              r_state     <= ST_UNLOAD;
              r_sin_ready <= 1'b0;
            end
          end else begin
            r_cap_cnt <= r_cap_cnt + 4'd1;
          end
        end
        ST_UNLOAD: begin
          if (r_cnt == CNT_LAST) begin
            r_state      <= ST_DONE;
            r_cnt        <= CNT_ZERO;
            r_se         <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= CNT_ZERO;
          r_cap_cnt    <= 4'd0;
          r_se         <= 1'b0;
          r_sin_ready  <= 1'b0;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign se         = r_se;
  assign sin_ready  = r_sin_ready;
  assign si         = r_sin_ready & sin;
  assign sout_valid = r_sout_valid;
  assign sout       = r_sout_valid & so;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef LA_SCANCTRL_MISR_EN
  logic w_misr_clear;

  assign w_misr_clear = (r_state == ST_IDLE) && start;

  la_scanmisr u_misr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_misr_clear),
    .i_en    (r_sout_valid),
    .i_din   (so),
    .o_sig   (signature)
  );
`endif

endmodule

// File: tb/tb_la_scanctrl.sv
// Directed bench for la_scanctrl: an 8-flop loopback chain whose flops capture
// their own inverted output, a sout scoreboard, and an NCAPTURE=3 instance.
module tb_la_scanctrl;

  logic clk;
  logic reset, start, next, sin;
  logic sin_ready, se, si, sout, sout_valid, busy, done;
  logic so;
  logic [7:0] chain;

  logic start3, next3, sin3, so3;
  logic sin_ready3, se3, si3, sout3, sout_valid3, busy3, done3;

`ifdef LA_SCANCTRL_MISR_EN
  logic [15:0] sig_main, sig3;
`endif

  int total = 0;
  int bad   = 0;
  logic sbq[$];

  la_scanctrl #(.CHAIN_LEN(8), .NCAPTURE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .next(next), .sin(sin),
    .sin_ready(sin_ready), .so(so), .se(se), .si(si), .sout(sout),
    .sout_valid(sout_valid), .busy(busy), .done(done)
`ifdef LA_SCANCTRL_MISR_EN
    , .signature(sig_main)
`endif
  );

  la_scanctrl #(.CHAIN_LEN(8), .NCAPTURE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .next(next3), .sin(sin3),
    .sin_ready(sin_ready3), .so(so3), .se(se3), .si(si3), .sout(sout3),
    .sout_valid(sout_valid3), .busy(busy3), .done(done3)
`ifdef LA_SCANCTRL_MISR_EN
    , .signature(sig3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback chain of la_sdffqn-style flops: scan shift when se, else capture ~Q
  always_ff @(posedge clk) begin
    if (se) chain <= {chain[6:0], si};
    else    chain <= ~chain;
  end
  assign so = chain[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_sample(input string tag);
    logic e;
    if (sout_valid === 1'b1) begin
      chk1({tag, "_sb_nonempty"}, sbq.size() != 0, 1'b1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk1({tag, "_sout"}, sout, e);
      end
    end
  endtask

  // One full sequence; ovl chains a second pattern via next on the first CAPTURE
  task automatic run_seq(input string tag, input logic ovl, input logic [7:0] p1, input logic [7:0] p2);
    int   last;
    logic sh, un, b;
    last = ovl ? 27 : 18;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      sh = (c <= 8) || (ovl && c >= 10 && c <= 17);
      un = (c >= last - 8) && (c <= last - 1);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_se"}, se, sh | un);
      chk1({tag, "_sin_ready"}, sin_ready, sh);
      chk1({tag, "_sout_valid"}, sout_valid, un || (ovl && c >= 10 && c <= 17));
      chk1({tag, "_done"}, done, c == last);
      sb_sample(tag);
      b = (c <= 8) ? p1[8 - c] : p2[17 - c];
      if (sh) begin
        sin = b;
        sbq.push_back(~b);
      end else begin
        sin = 1'b1;
      end
      #1;
      chk1({tag, "_si"}, si, sh ? b : 1'b0);
      next  = ovl && (c == 9);
      start = (c == last);
      tick();
      start = 1'b0;
      next  = 1'b0;
    end
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_done"}, done, 1'b0);
    chk1({tag, "_sb_drained"}, sbq.size() == 0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; next = 1'b0; sin = 1'b0;
    start3 = 1'b0; next3 = 1'b0; sin3 = 1'b0; so3 = 1'b1;
    repeat (3) tick();

    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_se", se, 1'b0);
    chk1("rst_si", si, 1'b0);
    chk1("rst_sin_ready", sin_ready, 1'b0);
    chk1("rst_sout", sout, 1'b0);
    chk1("rst_sout_valid", sout_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
`ifdef LA_SCANCTRL_MISR_EN
    chk16("rst_sig", sig_main, 16'h0000);
    chk16("rst_sig3", sig3, 16'h0000);
`endif
    reset = 1'b0;
    tick();
    chk1("idle_hold_busy", busy, 1'b0);

    // Basic sequence with 0xA5, start during DONE ignored
    run_seq("basic", 1'b0, 8'hA5, 8'h00);
    tick();
    chk1("done_start_ignored", busy, 1'b0);

    // Overlapped load/unload
    run_seq("ovl", 1'b1, 8'h3C, 8'h96);

    // Reset on SHIFT cycle 4 aborts, then a full rerun
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sin = c[0];
      tick();
    end
    chk1("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_se", se, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_sin_ready", sin_ready, 1'b0);
    chk1("abort_sout_valid", sout_valid, 1'b0);
    sbq.delete();
    tick();
    chk1("abort_idle_busy", busy, 1'b0);
    run_seq("rerun", 1'b0, 8'h5A, 8'h00);

    // NCAPTURE=3 instance with so held at 1, run twice
    for (int r = 0; r < 2; r++) begin
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        chk1("nc3_busy", busy3, 1'b1);
        chk1("nc3_se", se3, !((c >= 9 && c <= 11) || c == 20));
        chk1("nc3_sin_ready", sin_ready3, c <= 8);
        chk1("nc3_si", si3, 1'b0);
        chk1("nc3_sout_valid", sout_valid3, c >= 12 && c <= 19);
        chk1("nc3_sout", sout3, c >= 12 && c <= 19);
        chk1("nc3_done", done3, c == 20);
`ifdef LA_SCANCTRL_MISR_EN
        if (c == 20) chk16("misr_done", sig3, 16'h00FF);
`endif
        start3 = (c == 20);
        tick();
        start3 = 1'b0;
      end
      chk1("nc3_idle_busy", busy3, 1'b0);
      tick();
      chk1("nc3_start_ignored", busy3, 1'b0);
`ifdef LA_SCANCTRL_MISR_EN
      chk16("misr_hold", sig3, 16'h00FF);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
